// File: rtl/sc_regbank_pkg.sv
// Purpose: shared codes and default widths for the datapath register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshake; the state machine drives selections every cycle).
package sc_regbank_pkg;

  // Default bus and selection widths
  localparam int DATAWIDTH_BUS_DEF               = 8;
  localparam int DATAWIDTH_DECODER_SELECTION_DEF = 3;
  localparam int DATAWIDTH_MUX_SELECTION_DEF     = 3;
  localparam int NUM_GEN_REGS                    = 4;
  localparam int FLAG_W                          = 4;

  // Decoder (clear/load) codes; 100..110 are unused and 111 is idle
  typedef enum logic [2:0] {
    SEL_GEN0 = 3'b000,
    SEL_GEN1 = 3'b001,
    SEL_GEN2 = 3'b010,
    SEL_GEN3 = 3'b011,
    SEL_NONE = 3'b111
  } sel_code_e;

  // BUSA/BUSB source codes; 110 and 111 read as all-zeros
  typedef enum logic [2:0] {
    MUX_GEN0 = 3'b000,
    MUX_GEN1 = 3'b001,
    MUX_GEN2 = 3'b010,
    MUX_GEN3 = 3'b011,
    MUX_FIX0 = 3'b100,
    MUX_FIX1 = 3'b101
  } mux_code_e;

  // Bit positions inside the active-low flag nibble
  localparam int OVF = 3;
  localparam int CRY = 2;
  localparam int NEG = 1;
  localparam int ZER = 0;

  // Idle (nothing asserted) value of the active-low flag nibble
  localparam logic [FLAG_W-1:0] FLAGS_IDLE = 4'b1111;

endpackage

// File: rtl/sc_regbank_register.sv
// Purpose: one bank register with async reset value, synchronous clear and load.
// Latency: new value visible one cycle after the clock edge; clear beats load.
// Backpressure: none; a load or clear always takes effect on the edge.
module sc_regbank_register #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // State update: reset to INIT, clear has priority over load, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= INIT;
    end else if (clear) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/sc_regbank.sv
// Purpose: 4 general + 2 fixed registers; writes BUSC, drives BUSA/BUSB to the ALU (flags via SC_REGBANK_FLAGS_EN).
// Latency: reads are combinational; a write shows on BUSA/BUSB the cycle after its edge (no bypass).
// Backpressure: none; every selection is acted on at each rising edge, out-of-range codes are ignored.
module sc_regbank
  import sc_regbank_pkg::*;
#(
  parameter int                         DATAWIDTH_BUS               = DATAWIDTH_BUS_DEF,
  parameter int                         DATAWIDTH_DECODER_SELECTION = DATAWIDTH_DECODER_SELECTION_DEF,
  parameter int                         DATAWIDTH_MUX_SELECTION     = DATAWIDTH_MUX_SELECTION_DEF,
  parameter logic [DATAWIDTH_BUS-1:0]   FIX0_INIT                   = 8'h01,
  parameter logic [DATAWIDTH_BUS-1:0]   FIX1_INIT                   = 8'h02
) (
  input  logic                                   SC_STATEMACHINE_CLOCK_50,
  input  logic                                   SC_STATEMACHINE_RESET_InHigh,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_REGBANK_clearselection_InBUS,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_REGBANK_loadselection_InBUS,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_REGBANK_muxselectionBUSA_InBUS,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_REGBANK_muxselectionBUSB_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]               SC_REGBANK_BUSC_InBUS,
  input  logic [FLAG_W-1:0]                      SC_REGBANK_flags_InLow,
  output logic [DATAWIDTH_BUS-1:0]               SC_REGBANK_BUSA_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]               SC_REGBANK_BUSB_OutBUS,
  output logic [FLAG_W-1:0]                      SC_REGBANK_flags_OutLow
);

  logic [NUM_GEN_REGS-1:0]  clear_vec;
  logic [NUM_GEN_REGS-1:0]  load_vec;
  logic [DATAWIDTH_BUS-1:0] gen_q [NUM_GEN_REGS];
  logic [DATAWIDTH_BUS-1:0] fix0_q;
  logic [DATAWIDTH_BUS-1:0] fix1_q;

  // General registers: one-hot decode of clear/load; codes 100..111 decode to nothing
  for (genvar i = 0; i < NUM_GEN_REGS; i++) begin : g_gen
    assign clear_vec[i] = (SC_REGBANK_clearselection_InBUS == DATAWIDTH_DECODER_SELECTION'(i));
    assign load_vec[i]  = (SC_REGBANK_loadselection_InBUS  == DATAWIDTH_DECODER_SELECTION'(i));

    sc_regbank_register #(
      .WIDTH (DATAWIDTH_BUS),
      .INIT  ('0)
    ) u_gen (
      .clk      (SC_STATEMACHINE_CLOCK_50),
      .rst      (SC_STATEMACHINE_RESET_InHigh),
      .clear    (clear_vec[i]),
      .load     (load_vec[i]),
      .data_in  (SC_REGBANK_BUSC_InBUS),
      .data_out (gen_q[i])
    );
  end

  // Fixed registers have no decoder code, so their write controls are tied off
  sc_regbank_register #(
    .WIDTH (DATAWIDTH_BUS),
    .INIT  (FIX0_INIT)
  ) u_fix0 (
    .clk      (SC_STATEMACHINE_CLOCK_50),
    .rst      (SC_STATEMACHINE_RESET_InHigh),
    .clear    (1'b0),
    .load     (1'b0),
    .data_in  ('0),
    .data_out (fix0_q)
  );

  sc_regbank_register #(
    .WIDTH (DATAWIDTH_BUS),
    .INIT  (FIX1_INIT)
  ) u_fix1 (
    .clk      (SC_STATEMACHINE_CLOCK_50),
    .rst      (SC_STATEMACHINE_RESET_InHigh),
    .clear    (1'b0),
    .load     (1'b0),
    .data_in  ('0),
    .data_out (fix1_q)
  );

  // BUSA source select straight from register outputs; no BUSC bypass so BUSC->ALU->BUSA never loops
  always_comb begin
    SC_REGBANK_BUSA_OutBUS = '0;
    case (SC_REGBANK_muxselectionBUSA_InBUS)
      DATAWIDTH_MUX_SELECTION'(MUX_GEN0): SC_REGBANK_BUSA_OutBUS = gen_q[0];
      DATAWIDTH_MUX_SELECTION'(MUX_GEN1): SC_REGBANK_BUSA_OutBUS = gen_q[1];
      DATAWIDTH_MUX_SELECTION'(MUX_GEN2): SC_REGBANK_BUSA_OutBUS = gen_q[2];
      DATAWIDTH_MUX_SELECTION'(MUX_GEN3): SC_REGBANK_BUSA_OutBUS = gen_q[3];
      DATAWIDTH_MUX_SELECTION'(MUX_FIX0): SC_REGBANK_BUSA_OutBUS = fix0_q;
      DATAWIDTH_MUX_SELECTION'(MUX_FIX1): SC_REGBANK_BUSA_OutBUS = fix1_q;
      default:                            SC_REGBANK_BUSA_OutBUS = '0;
    endcase
  end

  // BUSB source select, identical decode to BUSA so both may share a source
  always_comb begin
    SC_REGBANK_BUSB_OutBUS = '0;
    case (SC_REGBANK_muxselectionBUSB_InBUS)
      DATAWIDTH_MUX_SELECTION'(MUX_GEN0): SC_REGBANK_BUSB_OutBUS = gen_q[0];
      DATAWIDTH_MUX_SELECTION'(MUX_GEN1): SC_REGBANK_BUSB_OutBUS = gen_q[1];
      DATAWIDTH_MUX_SELECTION'(MUX_GEN2): SC_REGBANK_BUSB_OutBUS = gen_q[2];
      DATAWIDTH_MUX_SELECTION'(MUX_GEN3): SC_REGBANK_BUSB_OutBUS = gen_q[3];
      DATAWIDTH_MUX_SELECTION'(MUX_FIX0): SC_REGBANK_BUSB_OutBUS = fix0_q;
      DATAWIDTH_MUX_SELECTION'(MUX_FIX1): SC_REGBANK_BUSB_OutBUS = fix1_q;
      default:                            SC_REGBANK_BUSB_OutBUS = '0;
    endcase
  end

`ifdef SC_REGBANK_FLAGS_EN
  logic [FLAG_W-1:0] flag_q;

  // Flag capture on any valid general-register load; a simultaneous clear does not block it
  always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
    if (SC_STATEMACHINE_RESET_InHigh) begin
      flag_q <= FLAGS_IDLE;
    end else if (|load_vec) begin
      flag_q <= SC_REGBANK_flags_InLow;
    end
  end

  assign SC_REGBANK_flags_OutLow = flag_q;
`else
  // Flags disabled: report no flag asserted and ignore the ALU flag input
  logic unused_flags_in;
  assign unused_flags_in         = ^SC_REGBANK_flags_InLow;
  assign SC_REGBANK_flags_OutLow = FLAGS_IDLE;
`endif

endmodule

// File: tb/tb_sc_regbank.sv
module tb_sc_regbank;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] clr_sel;
  logic [2:0] ld_sel;
  logic [2:0] sel_a;
  logic [2:0] sel_b;
  logic [7:0] busc;
  logic [3:0] flags_in;
  logic [7:0] bus_a;
  logic [7:0] bus_b;
  logic [3:0] flags_out;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sc_regbank dut (
    .SC_STATEMACHINE_CLOCK_50          (clk),
    .SC_STATEMACHINE_RESET_InHigh      (rst),
    .SC_REGBANK_clearselection_InBUS   (clr_sel),
    .SC_REGBANK_loadselection_InBUS    (ld_sel),
    .SC_REGBANK_muxselectionBUSA_InBUS (sel_a),
    .SC_REGBANK_muxselectionBUSB_InBUS (sel_b),
    .SC_REGBANK_BUSC_InBUS             (busc),
    .SC_REGBANK_flags_InLow            (flags_in),
    .SC_REGBANK_BUSA_OutBUS            (bus_a),
    .SC_REGBANK_BUSB_OutBUS            (bus_b),
    .SC_REGBANK_flags_OutLow           (flags_out)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move just past the next rising edge so sampling stays away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read all four general registers (two per bus) and compare
  task automatic check_gen(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    sel_a = 3'b000; sel_b = 3'b001; #1;
    check({tag, "_r0"}, bus_a, e0);
    check({tag, "_r1"}, bus_b, e1);
    sel_a = 3'b010; sel_b = 3'b011; #1;
    check({tag, "_r2"}, bus_a, e2);
    check({tag, "_r3"}, bus_b, e3);
  endtask

  task automatic idle();
    clr_sel = 3'b111;
    ld_sel  = 3'b111;
  endtask

  logic [3:0] exp_flags;

  initial begin
    rst = 1'b1; idle(); sel_a = 3'b100; sel_b = 3'b101; busc = 8'h00; flags_in = 4'b1111;
    #2;
    // 1: reset contents visible while reset held
    check("rst_fix0", bus_a, 8'h01);
    check("rst_fix1", bus_b, 8'h02);
    check("rst_flags", {4'h0, flags_out}, 8'h0F);
    check_gen("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    tick();

    // 2: load GenREG_2; not visible in the load cycle, visible next cycle
    ld_sel = 3'b010; busc = 8'hA5; sel_a = 3'b010; #1;
    check("ld2_same_cycle", bus_a, 8'h00);
    tick();
    idle(); #1;
    check("ld2_next_cycle", bus_a, 8'hA5);
    check_gen("ld2", 8'h00, 8'h00, 8'hA5, 8'h00);

    // 3: clear vs load priority and concurrent clear/load on different regs
    ld_sel = 3'b001; busc = 8'h3C; tick();
    ld_sel = 3'b000; busc = 8'h11; tick();
    idle();
    check_gen("pre_clr", 8'h11, 8'h3C, 8'hA5, 8'h00);
    clr_sel = 3'b001; ld_sel = 3'b001; busc = 8'hFF; tick();
    idle();
    check_gen("clr_wins", 8'h11, 8'h00, 8'hA5, 8'h00);
    clr_sel = 3'b000; ld_sel = 3'b011; busc = 8'hFF; tick();
    idle();
    check_gen("clr_ld_split", 8'h00, 8'h00, 8'hA5, 8'hFF);

    // 4: zero codes, shared source, out-of-range writes
    ld_sel = 3'b000; busc = 8'h10; tick();
    ld_sel = 3'b001; busc = 8'h20; tick();
    idle();
    sel_a = 3'b110; sel_b = 3'b111; #1;
    check("mux110_zero", bus_a, 8'h00);
    check("mux111_zero", bus_b, 8'h00);
    sel_a = 3'b011; sel_b = 3'b011; #1;
    check("shared_a", bus_a, 8'hFF);
    check("shared_b", bus_b, 8'hFF);
    busc = 8'h77;
    for (int c = 4; c <= 6; c++) begin
      ld_sel = 3'(c); clr_sel = 3'(c); tick();
    end
    idle();
    check_gen("oor", 8'h10, 8'h20, 8'hA5, 8'hFF);
    sel_a = 3'b100; sel_b = 3'b101; #1;
    check("oor_fix0", bus_a, 8'h01);
    check("oor_fix1", bus_b, 8'h02);

    // 5: asynchronous reset between edges during a load
    ld_sel = 3'b010; busc = 8'h55; tick();
    rst = 1'b1; #1;
    check_gen("mid_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    idle(); #1;
    rst = 1'b0;
    tick();
    check_gen("post_rst", 8'h00, 8'h00, 8'h00, 8'h00);
    ld_sel = 3'b010; busc = 8'h55; tick();
    idle();
    check_gen("reload", 8'h00, 8'h00, 8'h55, 8'h00);

    // 6: flag capture/hold (or constant idle when flags are compiled out)
    check("flags_after_rst", {4'h0, flags_out}, 8'h0F);
    ld_sel = 3'b000; busc = 8'h09; flags_in = 4'b1010; tick();
    idle(); flags_in = 4'b0000; #1;
`ifdef SC_REGBANK_FLAGS_EN
    exp_flags = 4'b1010;
`else
    exp_flags = 4'b1111;
`endif
    check("flags_capture", {4'h0, flags_out}, {4'h0, exp_flags});
    tick();
    check("flags_hold", {4'h0, flags_out}, {4'h0, exp_flags});
    clr_sel = 3'b001; ld_sel = 3'b001; flags_in = 4'b0101; tick();
    idle(); flags_in = 4'b1111; #1;
`ifdef SC_REGBANK_FLAGS_EN
    exp_flags = 4'b0101;
`else
    exp_flags = 4'b1111;
`endif
    check("flags_with_clear", {4'h0, flags_out}, {4'h0, exp_flags});
    check_gen("flags_regs", 8'h09, 8'h00, 8'h55, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sc_regbank.md
Name: sc_regbank

Overview:
- Datapath register bank directly downstream of the control state machine.
- Consumes the decoder clear/load selections and the BUSA/BUSB mux selections.
- Holds 4 general registers and 2 fixed registers, writes BUSC (the ALU/shifter result) into the selected general register, and drives BUSA/BUSB to the ALU.
- Optionally latches the ALU status flags and returns them, active-low, to the state machine.

Parameters:
- DATAWIDTH_BUS, 8, width of BUSA/BUSB/BUSC and of every register.
- DATAWIDTH_DECODER_SELECTION, 3, width of the clear/load selection buses.
- DATAWIDTH_MUX_SELECTION, 3, width of the BUSA/BUSB selection buses.
- FIX0_INIT, 8'h01, reset/constant value of RegFIX_0.
- FIX1_INIT, 8'h02, reset/constant value of RegFIX_1.

Ports:
- SC_STATEMACHINE_CLOCK_50  in  1  clock (already decided).
- SC_STATEMACHINE_RESET_InHigh  in  1  reset, asynchronous, active-high (already decided).
- SC_REGBANK_clearselection_InBUS  in  DATAWIDTH_DECODER_SELECTION  general register to clear.
- SC_REGBANK_loadselection_InBUS  in  DATAWIDTH_DECODER_SELECTION  general register to load from BUSC.
- SC_REGBANK_muxselectionBUSA_InBUS  in  DATAWIDTH_MUX_SELECTION  BUSA source.
- SC_REGBANK_muxselectionBUSB_InBUS  in  DATAWIDTH_MUX_SELECTION  BUSB source.
- SC_REGBANK_BUSC_InBUS  in  DATAWIDTH_BUS  write data.
- SC_REGBANK_flags_InLow  in  4  ALU flags {overflow, carry, negative, zero}, active-low.
- SC_REGBANK_BUSA_OutBUS  out  DATAWIDTH_BUS  to ALU operand A.
- SC_REGBANK_BUSB_OutBUS  out  DATAWIDTH_BUS  to ALU operand B.
- SC_REGBANK_flags_OutLow  out  4  latched flags to the state machine, active-low.

Behaviour:
- Decoder encoding:
  - 000..011 selects GenREG_0..3.
  - 100..111 selects nothing; 111 is the idle code.
- Mux encoding:
  - 000..011 selects GenREG_0..3.
  - 100 selects RegFIX_0; 101 selects RegFIX_1.
  - 110 and 111 drive all-zeros.
- Reset (async, any time including mid-write):
  - GenREG_0..3 = 0.
  - RegFIX_0 = FIX0_INIT; RegFIX_1 = FIX1_INIT.
  - Flag register = 4'b1111.
  - BUSA/BUSB therefore reflect reset contents immediately.
- Clear: on a rising clock edge, the register selected by the clear selection becomes 0.
- Load: on a rising clock edge, the register selected by the load selection takes BUSC.
- Clear and load on different registers in the same cycle: both take effect.
- Clear and load on the same register in the same cycle: clear wins, result 0.
- Fixed registers are read-only and change only on reset; there is no decoder code for them.
- Reads:
  - Combinational from current register contents, zero latency.
  - A write becomes visible on BUSA/BUSB in the cycle after the edge.
  - No write-through bypass; this avoids the BUSC->ALU->BUSA loop.
- Both buses may select the same source simultaneously; each gets an identical value.
- BUSC width equals register width; there is no truncation or extension.
- Out-of-range selection codes never alter state.

Optional Feature:
- Macro: SC_REGBANK_FLAGS_EN.
- Defined:
  - A 4-bit flag register captures SC_REGBANK_flags_InLow on every edge where the load selection is 000..011.
  - The flag register holds otherwise.
  - A simultaneous clear does not block the capture.
  - SC_REGBANK_flags_OutLow = flag register.
- Undefined:
  - No flag register.
  - SC_REGBANK_flags_OutLow is tied to 4'b1111 (no flag asserted).
  - SC_REGBANK_flags_InLow is ignored.

Decomposition:
- Shared package holds:
  - Decoder codes: SEL_GEN0..SEL_GEN3, SEL_NONE=3'b111.
  - Mux codes: MUX_GEN0..3, MUX_FIX0=3'b100, MUX_FIX1=3'b101.
  - Flag bit indices: OVF=3, CRY=2, NEG=1, ZER=0.
  - Default DATAWIDTH_* values.
- One natural sub-module, sc_regbank_register: a single DATAWIDTH_BUS register with async reset value, synchronous clear (priority) and load. It is instantiated ×4 for general registers and ×2 for fixed registers, with load/clear tied inactive.

Test Plan:
1. Reset, all selections idle (111) -> BUSA with sel 100 = 8'h01; BUSB with sel 101 = 8'h02; sel 000..011 read 0; flags_OutLow = 4'b1111.
2. Load 010 with BUSC=8'hA5, BUSA sel 010 -> BUSA still 0 in the load cycle, 8'hA5 the next cycle; other registers unchanged.
3. Load GenREG_1=8'h3C, then clear=001 and load=001 with BUSC=8'hFF in one cycle -> GenREG_1 = 0; same cycle with clear=000, load=011 -> GenREG_0=0 and GenREG_3=8'hFF.
4. BUSA sel 110 and BUSB sel 111 with all registers nonzero -> both buses 8'h00; load=100..110 with BUSC=8'h77 -> no register changes.
5. Reset asserted between edges during a load of 8'h55 into GenREG_2 -> GenREG_2=0 immediately; no write after reset release until the next valid load.
6. With SC_REGBANK_FLAGS_EN: load=000 with flags_InLow=4'b1010 -> flags_OutLow=4'b1010 next cycle; idle cycle with flags_InLow=4'b0000 -> output holds 4'b1010. Without the macro: output constant 4'b1111.
